// File: rtl/snake_step_ctrl.sv
// Snake game step scheduler: counts VGA frames, moves the head one cell every
// FRAMES_PER_STEP frames and detects wall hits. Define SNAKE_WRAP_EN to wrap at the edges instead.
module snake_step_ctrl #(
    parameter int unsigned GRID_W          = 40,
    parameter int unsigned GRID_H          = 30,
    parameter int unsigned FRAMES_PER_STEP = 8,
    parameter int unsigned START_X         = 20,
    parameter int unsigned START_Y         = 15
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iV_SYNC,
    input  logic       iStart,
    input  logic       iDir_Valid,
    input  logic [1:0] iDir,
    output logic [5:0] oHead_X,
    output logic [5:0] oHead_Y,
    output logic       oStep,
    output logic       oDead,
    output logic [1:0] oState
);

    localparam int unsigned CNT_W = 8;
    localparam logic [1:0] D_UP    = 2'b00;
    localparam logic [1:0] D_DOWN  = 2'b01;
    localparam logic [1:0] D_LEFT  = 2'b10;
    localparam logic [1:0] D_RIGHT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DEAD = 2'b10
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [5:0]         r_head_x, r_head_y, w_head_x_nxt, w_head_y_nxt;
    logic [1:0]         r_cur_dir, r_pend_dir, w_cur_dir_nxt, w_pend_dir_nxt;
    logic [CNT_W-1:0]   r_frame_cnt, w_frame_cnt_nxt;
    logic               r_vs_d;
    logic               r_step, w_step_nxt;
    logic               w_tick;
    logic               w_dir_ok;
    logic signed [6:0]  w_nx, w_ny;
    logic               w_out_x, w_out_y;
`ifdef SNAKE_WRAP_EN
    logic [5:0]         w_wrap_x, w_wrap_y;
`endif

    // End of the active-low sync pulse marks one frame
    assign w_tick   = iV_SYNC & ~r_vs_d;
    // Reversal is rejected only against the direction actually travelled
    assign w_dir_ok = (iDir != (r_cur_dir ^ 2'b01));

    // Candidate next head; signed so that 0-1 stays negative
    always_comb begin
        w_nx = 7'(r_head_x);
        w_ny = 7'(r_head_y);
        case (r_pend_dir)
            D_UP:    w_ny = w_ny - 7'sd1;
            D_DOWN:  w_ny = w_ny + 7'sd1;
            D_LEFT:  w_nx = w_nx - 7'sd1;
            default: w_nx = w_nx + 7'sd1;
        endcase
    end

    assign w_out_x = w_nx[6] | (w_nx[5:0] >= 6'(GRID_W));
    assign w_out_y = w_ny[6] | (w_ny[5:0] >= 6'(GRID_H));

`ifdef SNAKE_WRAP_EN
    assign w_wrap_x = w_nx[6] ? 6'(GRID_W - 1) : (w_out_x ? 6'd0 : w_nx[5:0]);
    assign w_wrap_y = w_ny[6] ? 6'(GRID_H - 1) : (w_out_y ? 6'd0 : w_ny[5:0]);
`endif

    // Next-state and datapath update
    always_comb begin
        w_state_nxt     = r_state;
        w_head_x_nxt    = r_head_x;
        w_head_y_nxt    = r_head_y;
        w_cur_dir_nxt   = r_cur_dir;
        w_pend_dir_nxt  = r_pend_dir;
        w_frame_cnt_nxt = r_frame_cnt;
        w_step_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_head_x_nxt    = 6'(START_X);
                w_head_y_nxt    = 6'(START_Y);
                w_cur_dir_nxt   = D_RIGHT;
                w_frame_cnt_nxt = '0;
                if (iDir_Valid && w_dir_ok) w_pend_dir_nxt = iDir;
                if (iStart) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (iDir_Valid && w_dir_ok) w_pend_dir_nxt = iDir;
                if (w_tick) begin
                    if (r_frame_cnt == CNT_W'(FRAMES_PER_STEP - 1)) begin
                        w_frame_cnt_nxt = '0;
`ifdef SNAKE_WRAP_EN
                        w_head_x_nxt  = w_wrap_x;
                        w_head_y_nxt  = w_wrap_y;
                        w_cur_dir_nxt = r_pend_dir;
                        w_step_nxt    = 1'b1;
`else
                        if (w_out_x || w_out_y) begin
                            w_state_nxt = S_DEAD;
                        end else begin
                            w_head_x_nxt  = w_nx[5:0];
                            w_head_y_nxt  = w_ny[5:0];
                            w_cur_dir_nxt = r_pend_dir;
                            w_step_nxt    = 1'b1;
                        end
`endif
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + CNT_W'(1);
                    end
                end
            end
            S_DEAD: begin
                if (iStart) begin
                    w_state_nxt     = S_IDLE;
                    w_head_x_nxt    = 6'(START_X);
                    w_head_y_nxt    = 6'(START_Y);
                    w_cur_dir_nxt   = D_RIGHT;
                    w_pend_dir_nxt  = D_RIGHT;
                    w_frame_cnt_nxt = '0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state     <= S_IDLE;
            r_head_x    <= 6'(START_X);
            r_head_y    <= 6'(START_Y);
            r_cur_dir   <= D_RIGHT;
            r_pend_dir  <= D_RIGHT;
            r_frame_cnt <= '0;
            r_vs_d      <= 1'b0;
            r_step      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_head_x    <= w_head_x_nxt;
            r_head_y    <= w_head_y_nxt;
            r_cur_dir   <= w_cur_dir_nxt;
            r_pend_dir  <= w_pend_dir_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_vs_d      <= iV_SYNC;
            r_step      <= w_step_nxt;
        end
    end

    assign oHead_X = r_head_x;
    assign oHead_Y = r_head_y;
    assign oStep   = r_step;
    assign oDead   = (r_state == S_DEAD);
    assign oState  = r_state;

endmodule

// File: doc/snake_step_ctrl.md
Name: snake_step_ctrl

Overview:
- Frame-rate game scheduler for the snake display.
- Counts VGA frames from the vertical sync of the VGA controller and advances the snake head one grid cell every FRAMES_PER_STEP frames.
- Applies the latched player direction and detects wall collisions.
- Outputs the head cell coordinates and game state to the pixel/colour generator, which draws the cell during active video.

Parameters:
- GRID_W, 40, grid width in cells (max 63).
- GRID_H, 30, grid height in cells (max 63).
- FRAMES_PER_STEP, 8, frames between head moves (1..255).
- START_X, 20, head X after init.
- START_Y, 15, head Y after init.

Ports:
- iCLK  in  1  pixel clock, same clock as the VGA controller.
- iRST_N  in  1  reset.
- iV_SYNC  in  1  vertical sync from VGA controller, active low.
- iStart  in  1  start/restart request, level sampled.
- iDir_Valid  in  1  direction request strobe.
- iDir  in  2  requested direction: 00 UP, 01 DOWN, 10 LEFT, 11 RIGHT.
- oHead_X  out  6  head cell column.
- oHead_Y  out  6  head cell row.
- oStep  out  1  one-cycle pulse on each head move.
- oDead  out  1  high in DEAD state.
- oState  out  2  00 IDLE, 01 RUN, 10 DEAD.

Interface (already decided): one clock, iCLK; reset iRST_N is asynchronous and active-low.

Behaviour:
- Reset (async, iRST_N low):
  - State IDLE.
  - oHead_X=START_X, oHead_Y=START_Y.
  - cur_dir=pend_dir=RIGHT.
  - frame_cnt=0, vs_d=0.
  - oStep=0, oDead=0, oState=00.
  - Reset asserted mid-RUN aborts immediately; no step pulse is emitted.
- Frame tick:
  - vs_d is iV_SYNC registered.
  - tick = iV_SYNC & ~vs_d (end of sync pulse); exactly one tick per frame.
- IDLE:
  - Head held at start, dirs RIGHT, frame_cnt=0.
  - iStart=1 -> RUN next cycle.
  - Direction requests are accepted in IDLE, with the reverse check against cur_dir=RIGHT.
- RUN:
  - Each tick: if frame_cnt==FRAMES_PER_STEP-1, then frame_cnt<=0 and a step occurs; else frame_cnt<=frame_cnt+1.
  - Step: next head = head moved one cell in pend_dir (UP y-1, DOWN y+1, LEFT x-1, RIGHT x+1).
  - If next head is inside [0,GRID_W-1]x[0,GRID_H-1]: oHead<=next, cur_dir<=pend_dir, oStep<=1 for one cycle.
  - If outside: head unchanged, oStep stays 0, state<=DEAD.
  - Bounds check uses a 7-bit signed intermediate so x=0 moving LEFT does not alias to 63.
  - Latency: tick cycle N -> oHead/oStep valid at N+1.
- Direction latch:
  - On iDir_Valid, pend_dir<=iDir unless iDir is the opposite of cur_dir (UP/DOWN, LEFT/RIGHT pairs). Opposite requests are dropped silently.
  - Same-direction and perpendicular requests are accepted.
  - Multiple requests between steps: last accepted one wins.
  - iDir_Valid in the same cycle as a step: the step uses the old pend_dir. The new request is checked against the old cur_dir and applies to the following step.
- DEAD:
  - oDead=1; head, dirs and frame_cnt frozen.
  - iStart=1 -> IDLE (full reinit as at reset); a second iStart is needed to RUN.
- iStart while RUN: ignored.
- oState mirrors state combinationally from the state register.

Optional Feature:
- Macro: SNAKE_WRAP_EN.
- Defined:
  - Leaving the grid wraps instead of killing: x=GRID_W-1 RIGHT -> x=0; x=0 LEFT -> x=GRID_W-1; same for Y with GRID_H.
  - The step always succeeds; DEAD is unreachable from RUN; oDead stays 0.
- Undefined: wall collision -> DEAD as above.

Test Plan:
- Reset then release, no iStart, 20 frames -> oState=00, head (20,15), oStep never high.
- iStart, 8 ticks (FRAMES_PER_STEP=8) -> single oStep one cycle after tick 8, head (21,15); 16 ticks total -> head (22,15).
- In RUN moving RIGHT, iDir=LEFT valid -> dropped, next step head x+1. Then iDir=UP -> next step y-1. Then iDir=DOWN -> dropped (opposite of new cur_dir UP).
- Head (39,15) RIGHT, next step tick -> no oStep, head stays (39,15), oState=10, oDead=1. iStart -> oState=00, head (20,15).
- With SNAKE_WRAP_EN: head (39,15) RIGHT -> (0,15), oStep=1; head (5,0) UP -> (5,29).
- iRST_N low for one cycle mid-RUN at frame_cnt=5 -> outputs immediately at reset values; after release, no oStep until iStart and 8 further ticks.
